// File: rtl/timer_pkg.sv
// Shared definitions for the mm:ss BCD stopwatch: FSM encoding, digit limits
// and the single-digit successor function used by every digit counter.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam logic [3:0] DIGIT_MAX_9 = 4'd9;
  localparam logic [3:0] DIGIT_MAX_5 = 4'd5;

  // Any value at or above the limit folds back to zero, so a digit can never
  // leave its legal range even if it were somehow disturbed.
  function automatic logic [3:0] bcd_next(input logic [3:0] d, input logic [3:0] max);
    logic [3:0] r;
    if (d >= max) r = 4'd0;
    else          r = d + 4'd1;
    return r;
  endfunction

endpackage

// File: rtl/bcd_cnt.sv
// One BCD digit counting 0..MAX. carry is combinational so four instances
// chain within a single clock; the digit itself is a register.
module bcd_cnt
  import timer_pkg::*;
#(
  parameter logic [3:0] MAX = DIGIT_MAX_9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  output logic [3:0] digit,
  output logic       carry
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      digit <= 4'd0;
    else if (clr) digit <= 4'd0;
    else if (en)  digit <= bcd_next(digit, MAX);
  end

  assign carry = en && !clr && (digit >= MAX);

endmodule

// File: rtl/timer_bcd.sv
// Minutes:seconds BCD stopwatch with a DIV-cycle prescaler and an
// IDLE/RUN/PAUSE controller. All outputs are registers.
//
// Handshake: start_stop and clear are single-cycle request pulses with no
// ready; each is acted on in the cycle it is high, clear taking priority.
module timer_bcd
  import timer_pkg::*;
#(
  parameter int unsigned DIV = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_stop,
  input  logic       clear,
  output logic [3:0] sec_lo,
  output logic [3:0] sec_hi,
  output logic [3:0] min_lo,
  output logic [3:0] min_hi,
  output logic       running,
  output logic       tick,
  output logic       wrap,
  output state_t     dbg_state
);

  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  state_t        state, state_next;
  logic [PW-1:0] presc, presc_next;
  logic          inc;
  logic          c_sec_lo, c_sec_hi, c_min_lo, c_min_hi;

  // A second completes on the last prescaler cycle of RUN unless cleared.
  assign inc = (state == ST_RUN) && (presc == PRE_LAST) && !clear;

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start_stop) state_next = ST_RUN;
      ST_RUN:   if (start_stop) state_next = ST_PAUSE;
      ST_PAUSE: if (start_stop) state_next = ST_RUN;
      default:  state_next = ST_IDLE;
    endcase
    if (clear) state_next = ST_IDLE;
  end

  // The prescaler only moves in RUN; PAUSE keeps the partial second.
  always_comb begin
    presc_next = presc;
    if (clear)
      presc_next = '0;
    else if (state == ST_RUN)
      presc_next = (presc == PRE_LAST) ? '0 : presc + PW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      presc   <= '0;
      running <= 1'b0;
      tick    <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      state   <= state_next;
      presc   <= presc_next;
      running <= (state_next == ST_RUN);
      tick    <= inc;
      wrap    <= c_min_hi;
    end
  end

  assign dbg_state = state;

  bcd_cnt #(.MAX(DIGIT_MAX_9)) u_sec_lo (
    .clk(clk), .rst(rst), .en(inc), .clr(clear), .digit(sec_lo), .carry(c_sec_lo)
  );

  bcd_cnt #(.MAX(DIGIT_MAX_5)) u_sec_hi (
    .clk(clk), .rst(rst), .en(c_sec_lo), .clr(clear), .digit(sec_hi), .carry(c_sec_hi)
  );

  bcd_cnt #(.MAX(DIGIT_MAX_9)) u_min_lo (
    .clk(clk), .rst(rst), .en(c_sec_hi), .clr(clear), .digit(min_lo), .carry(c_min_lo)
  );

  bcd_cnt #(.MAX(DIGIT_MAX_5)) u_min_hi (
    .clk(clk), .rst(rst), .en(c_min_lo), .clr(clear), .digit(min_hi), .carry(c_min_hi)
  );

endmodule

// File: tb/tb_timer_bcd.sv
// Bench for timer_bcd with DIV=4: directed scenarios plus random pulses,
// every cycle compared against an elapsed-seconds reference model.
module tb_timer_bcd;
  import timer_pkg::*;

  localparam int DIV = 4;

  logic       clk;
  logic       rst;
  logic       start_stop;
  logic       clear;
  logic [3:0] sec_lo, sec_hi, min_lo, min_hi;
  logic       running, tick, wrap;
  state_t     dbg_state;

  timer_bcd #(.DIV(DIV)) dut (
    .clk(clk), .rst(rst), .start_stop(start_stop), .clear(clear),
    .sec_lo(sec_lo), .sec_hi(sec_hi), .min_lo(min_lo), .min_hi(min_hi),
    .running(running), .tick(tick), .wrap(wrap), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  // Time is held as total elapsed seconds; phase is run-cycles into the second.
  int     m_secs;
  int     m_phase;
  state_t m_state;
  bit     m_tick;
  bit     m_wrap;

  int n_checks;
  int n_fail;
  logic [18:0] exp_q[$];

  task automatic model_reset();
    m_secs = 0; m_phase = 0; m_state = ST_IDLE; m_tick = 0; m_wrap = 0;
  endtask

  task automatic model_step(input bit ss, input bit cl);
    bit inc;
    if (cl) begin
      m_state = ST_IDLE; m_secs = 0; m_phase = 0; m_tick = 0; m_wrap = 0;
    end else begin
      inc    = (m_state == ST_RUN) && (m_phase == DIV - 1);
      m_tick = inc;
      m_wrap = inc && (m_secs == 3599);
      if (m_state == ST_RUN) m_phase = (m_phase + 1) % DIV;
      if (inc) m_secs = (m_secs + 1) % 3600;
      if (ss) m_state = (m_state == ST_RUN) ? ST_PAUSE : ST_RUN;
    end
  endtask

  function automatic logic [15:0] digits_of(input int s);
    logic [15:0] d;
    d[15:12] = 4'(s / 600);
    d[11:8]  = 4'((s / 60) % 10);
    d[7:4]   = 4'((s % 60) / 10);
    d[3:0]   = 4'(s % 10);
    return d;
  endfunction

  function automatic logic [18:0] model_vec();
    return {digits_of(m_secs), (m_state == ST_RUN), m_tick, m_wrap};
  endfunction

  wire [15:0] obs_digits = {min_hi, min_lo, sec_hi, sec_lo};
  wire [18:0] obs_vec    = {obs_digits, running, tick, wrap};

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the following negedge.
  task automatic cycle(input bit ss, input bit cl);
    start_stop = ss;
    clear      = cl;
    @(posedge clk);
    model_step(ss, cl);
    exp_q.push_back(model_vec());
    #1;
    check("cycle_out", obs_vec, exp_q.pop_front());
    check("cycle_state", dbg_state, m_state);
    @(negedge clk);
    start_stop = 1'b0;
    clear      = 1'b0;
  endtask

  task automatic run_until(input int target);
    int budget;
    budget = DIV * 3700;
    while (m_secs != target && budget > 0) begin
      cycle(1'b0, 1'b0);
      budget--;
    end
    if (budget == 0) check("run_until_timeout", 32'd0, 32'd1);
  endtask

  task automatic to_last_phase();
    int budget;
    budget = DIV + 2;
    while (!(m_state == ST_RUN && m_phase == DIV - 1) && budget > 0) begin
      cycle(1'b0, 1'b0);
      budget--;
    end
    if (budget == 0) check("phase_timeout", 32'd0, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    model_reset();
    rst = 1'b1; start_stop = 1'b1; clear = 1'b0;
    #12;
    check("reset_out", obs_vec, 19'd0);
    check("reset_state", dbg_state, ST_IDLE);
    @(posedge clk); #1;
    check("reset_ignores_start", running, 1'b0);
    @(negedge clk);
    start_stop = 1'b0;
    rst = 1'b0;

    // first seconds after start
    cycle(1'b1, 1'b0);
    check("run_next_cycle", running, 1'b1);
    repeat (DIV - 1) cycle(1'b0, 1'b0);
    check("no_early_tick", tick, 1'b0);
    cycle(1'b0, 1'b0);
    check("first_sec", sec_lo, 4'd1);
    check("first_tick", tick, 1'b1);
    repeat (DIV) cycle(1'b0, 1'b0);
    check("second_sec", sec_lo, 4'd2);

    // cascades and wrap
    run_until(9);
    run_until(10);
    check("roll_00_10", obs_digits, 16'h0010);
    run_until(59);
    run_until(60);
    check("roll_01_00", obs_digits, 16'h0100);
    run_until(599);
    run_until(600);
    check("roll_10_00", obs_digits, 16'h1000);
    run_until(3599);
    check("at_59_59", obs_digits, 16'h5959);
    run_until(0);
    check("wrap_digits", obs_digits, 16'h0000);
    check("wrap_pulse", wrap, 1'b1);
    check("wrap_running", running, 1'b1);
    cycle(1'b0, 1'b0);
    check("wrap_one_cycle", wrap, 1'b0);

    // pause after two prescaler cycles, hold, resume
    cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    check("paused", running, 1'b0);
    repeat (10) cycle(1'b0, 1'b0);
    check("pause_hold", obs_digits, 16'h0000);
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    check("resume_no_tick", tick, 1'b0);
    cycle(1'b0, 1'b0);
    check("resume_tick", tick, 1'b1);
    check("resume_sec", sec_lo, 4'd1);

    // start_stop coincident with the increment edge
    to_last_phase();
    cycle(1'b1, 1'b0);
    check("ss_inc_tick", tick, 1'b1);
    check("ss_inc_sec", sec_lo, 4'd2);
    check("ss_inc_pause", dbg_state, ST_PAUSE);

    // clear beats a pending increment
    cycle(1'b1, 1'b0);
    to_last_phase();
    cycle(1'b0, 1'b1);
    check("clr_inc_tick", tick, 1'b0);
    check("clr_inc_digits", obs_digits, 16'h0000);

    // clear and start_stop together at 03:27
    cycle(1'b1, 1'b0);
    run_until(207);
    check("at_03_27", obs_digits, 16'h0327);
    cycle(1'b1, 1'b1);
    check("clr_ss_digits", obs_digits, 16'h0000);
    check("clr_ss_running", running, 1'b0);
    check("clr_ss_state", dbg_state, ST_IDLE);

    // asynchronous reset between edges at 12:34, mid-second
    cycle(1'b1, 1'b0);
    run_until(754);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    check("at_12_34", obs_digits, 16'h1234);
    #2 rst = 1'b1;
    #1;
    check("async_rst_out", obs_vec, 19'd0);
    check("async_rst_state", dbg_state, ST_IDLE);
    #1 rst = 1'b0;
    model_reset();
    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    repeat (DIV - 1) cycle(1'b0, 1'b0);
    check("post_rst_full_sec", tick, 1'b0);
    cycle(1'b0, 1'b0);
    check("post_rst_tick", tick, 1'b1);

    // random pulses
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 7) == 0, $urandom_range(0, 59) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_bcd.md
TIMER_BCD -- requirements
Module: timer_bcd

Interface
REQ-001 SHALL provide parameter DIV, default 50000000, clock cycles per counted second (legal range 2..2^26).
REQ-002 SHALL provide port clk  input  1  single system clock, all state on rising edge.
REQ-003 SHALL provide port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL provide port start_stop  input  1  synchronous one-cycle pulse, toggles run/pause.
REQ-005 SHALL provide port clear  input  1  synchronous one-cycle pulse, zeroes time and stops.
REQ-006 SHALL provide port sec_lo  output  4  seconds units BCD digit, 0..9.
REQ-007 SHALL provide port sec_hi  output  4  seconds tens BCD digit, 0..5.
REQ-008 SHALL provide port min_lo  output  4  minutes units BCD digit, 0..9.
REQ-009 SHALL provide port min_hi  output  4  minutes tens BCD digit, 0..5.
REQ-010 SHALL provide port running  output  1  high while state is RUN.
REQ-011 SHALL provide port tick  output  1  one-cycle pulse coincident with each digit update.
REQ-012 SHALL provide port wrap  output  1  one-cycle pulse when time rolls 59:59 -> 00:00.

Function
REQ-013 SHALL implement states IDLE, RUN, PAUSE; IDLE after reset.
REQ-014 SHALL transition IDLE->RUN and PAUSE->RUN on start_stop, and RUN->PAUSE on start_stop.
REQ-015 SHALL, on clear, go to IDLE, zero all digits and the prescaler, from any state.
REQ-016 SHALL give clear priority over start_stop and over a pending increment in the same cycle.
REQ-017 SHALL advance the prescaler 0..DIV-1 only in RUN, restart it at 0 after DIV-1, and hold it (not zero it) in PAUSE.
REQ-018 SHALL increment the time by one second on the edge where the prescaler is at DIV-1 in RUN, so first update occurs DIV cycles after entering RUN from IDLE.
REQ-019 SHALL, when start_stop and prescaler = DIV-1 coincide in RUN, apply the increment and enter PAUSE.
REQ-020 SHALL cascade: sec_lo 9->0 carries to sec_hi; sec_hi 5->0 carries to min_lo; min_lo 9->0 carries to min_hi; min_hi 5->0 completes wrap.
REQ-021 SHALL, at 59:59 plus increment, show 00:00, pulse wrap, and remain in RUN.
REQ-022 SHALL register all outputs; tick and wrap high exactly in the cycle after the increment edge, same cycle the new digits appear.
REQ-023 SHALL never drive a digit outside its stated range, so downstream decoder defaults are never used.
REQ-024 SHALL keep running = 1 only in RUN, changing on the edge that changes state.

Reset
REQ-025 SHALL, on rst assertion, immediately set state IDLE, prescaler 0, all digits 0, running/tick/wrap 0, regardless of clk.
REQ-026 SHALL, on rst mid-count, discard the partial second; next start counts a full DIV cycles.
REQ-027 SHALL ignore start_stop and clear while rst is high.

Structure
REQ-028 SHALL place state encoding (IDLE/RUN/PAUSE) and digit limit constants (9, 5) in shared package timer_pkg.
REQ-029 SHALL instantiate one sub-module bcd_cnt (parameter MAX, inputs en/clr, outputs 4-bit digit and carry) four times, MAX = 9,5,9,5.
REQ-030 SHALL contain the prescaler and FSM in timer_bcd top; digits feed num_7seg instances externally.

Verification (DIV=4)
REQ-031 SHALL check: rst, start_stop pulse -> running=1 next cycle, sec_lo=1 and tick after 4 cycles, 2 after 8.
REQ-032 SHALL check: run to 00:09, one more second -> 00:10; at 00:59 -> 01:00; at 09:59 -> 10:00.
REQ-033 SHALL check: run to 59:59, one more second -> 00:00, wrap=1 one cycle, running stays 1.
REQ-034 SHALL check: pause after 2 prescaler cycles, hold 10 cycles, resume -> next increment 2 cycles after resume.
REQ-035 SHALL check: clear and start_stop same cycle at 03:27 in RUN -> 00:00, IDLE, running=0.
REQ-036 SHALL check: async rst pulse between clk edges at 12:34 -> outputs 00:00 immediately, no tick.
